// File: rtl/button_event_queue_if.sv
// Handshake bundle between the press conditioning stage, the event queue and the game logic.
// The master side is the queue; the slave side drives presses and consumes events.
interface button_event_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    btn_pulse;
    logic          evt_valid;
    logic [1:0]    evt_dir;
    logic          evt_ready;
    logic [CW-1:0] count;
    logic          dropped;

    modport master (
        input  btn_pulse,
        input  evt_ready,
        output evt_valid,
        output evt_dir,
        output count,
        output dropped
    );

    modport slave (
        output btn_pulse,
        output evt_ready,
        input  evt_valid,
        input  evt_dir,
        input  count,
        input  dropped
    );
endinterface

// File: rtl/button_event_queue.sv
// Priority-resolved, hold-off filtered key press queue (first-word fall-through) feeding
// the game logic through a valid/ready handshake.
module button_event_queue #(
    parameter int DEPTH   = 4,
    parameter int LOCKOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_event_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [LW-1:0] LOCK_C  = LW'(LOCKOUT);

    logic [1:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [LW-1:0] lock_cnt_r;
    logic          dropped_r;

    logic          press_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [1:0]    code_s;
    logic [CW-1:0] count_nxt_s;
    logic [LW-1:0] lock_nxt_s;

    // Highest set bit wins; lower simultaneous presses are discarded.
    function automatic logic [1:0] prio_encode(input logic [3:0] b);
        logic [1:0] code;
        casez (b)
            4'b1???: code = 2'd3;
            4'b01??: code = 2'd2;
            4'b001?: code = 2'd1;
            4'b0001: code = 2'd0;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // Press qualification, push/pop decisions and next-state values.
    always_comb begin
        press_s     = (bus.btn_pulse != 4'b0000) && (lock_cnt_r == {LW{1'b0}});
        pop_s       = (count_r != {CW{1'b0}}) && bus.evt_ready;
        push_s      = press_s && ((count_r < DEPTH_C) || pop_s);
        drop_s      = press_s && !push_s;
        code_s      = prio_encode(bus.btn_pulse);
        count_nxt_s = count_r;
        lock_nxt_s  = lock_cnt_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (press_s) begin
            lock_nxt_s = LOCK_C;
        end else if (lock_cnt_r != {LW{1'b0}}) begin
            lock_nxt_s = lock_cnt_r - LW'(1);
        end else begin
            lock_nxt_s = lock_cnt_r;
        end
    end

    // Control state: pointers, occupancy, hold-off counter and drop pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            lock_cnt_r <= {LW{1'b0}};
            dropped_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_nxt_s;
            lock_cnt_r <= lock_nxt_s;
            dropped_r  <= drop_s;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wr_ptr_r] <= code_s;
        end
    end

    // Head is forced to zero when empty so evt_dir never shows uninitialised storage.
    always_comb begin
        bus.evt_valid = (count_r != {CW{1'b0}});
        bus.count     = count_r;
        bus.dropped   = dropped_r;
        if (count_r != {CW{1'b0}}) begin
            bus.evt_dir = mem_r[rd_ptr_r];
        end else begin
            bus.evt_dir = 2'b00;
        end
    end
endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue: one instance with LOCKOUT=16 and one with LOCKOUT=0, both
// checked every cycle against a list-based model, plus directed scenarios with literal values.
module tb_button_event_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   started = 1'b0;

    button_event_queue_if #(.DEPTH(4)) ifa ();
    button_event_queue_if #(.DEPTH(4)) ifb ();

    button_event_queue #(.DEPTH(4), .LOCKOUT(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    button_event_queue #(.DEPTH(4), .LOCKOUT(0))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    // Model state per instance: an ordered list of codes, a hold-off count and the drop flag.
    int mq   [2][0:7];
    int msz  [2];
    int mlock[2];
    int mdrop[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic [3:0] b,
                              input logic rdy, input int lk);
        int  sz0;
        bit  pop;
        bit  press;
        int  code;
        if (!r) begin
            msz[i]   = 0;
            mlock[i] = 0;
            mdrop[i] = 0;
        end else begin
            sz0   = msz[i];
            pop   = (sz0 > 0) && rdy;
            press = (b != 4'b0000) && (mlock[i] == 0);
            code  = b[3] ? 3 : b[2] ? 2 : b[1] ? 1 : 0;
            mdrop[i] = 0;
            if (press) mlock[i] = lk;
            else if (mlock[i] > 0) mlock[i] = mlock[i] - 1;
            if (pop) begin
                for (int j = 0; j < 7; j++) mq[i][j] = mq[i][j+1];
                msz[i] = msz[i] - 1;
            end
            if (press) begin
                if (sz0 < 4 || pop) begin
                    mq[i][msz[i]] = code;
                    msz[i] = msz[i] + 1;
                end else begin
                    mdrop[i] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_n, ifa.btn_pulse, ifa.evt_ready, 16);
        model_step(1, rst_n, ifb.btn_pulse, ifb.evt_ready, 0);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            check("a_valid",   32'(ifa.evt_valid), 32'(msz[0] != 0));
            check("a_dir",     32'(ifa.evt_dir),   32'((msz[0] != 0) ? mq[0][0] : 0));
            check("a_count",   32'(ifa.count),     32'(msz[0]));
            check("a_dropped", 32'(ifa.dropped),   32'(mdrop[0]));
            check("b_valid",   32'(ifb.evt_valid), 32'(msz[1] != 0));
            check("b_dir",     32'(ifb.evt_dir),   32'((msz[1] != 0) ? mq[1][0] : 0));
            check("b_count",   32'(ifb.count),     32'(msz[1]));
            check("b_dropped", 32'(ifb.dropped),   32'(mdrop[1]));
        end
    end

    task automatic drive(input logic r, input logic [3:0] ba, input logic ra,
                         input logic [3:0] bb, input logic rb);
        @(negedge clk);
        rst_n         = r;
        ifa.btn_pulse = ba;
        ifa.evt_ready = ra;
        ifb.btn_pulse = bb;
        ifb.evt_ready = rb;
    endtask

    initial begin
        int exp_drain[4];
        logic [3:0] ra_b;
        logic [3:0] rb_b;
        rst_n = 1'b0;
        ifa.btn_pulse = 4'b0000; ifa.evt_ready = 1'b0;
        ifb.btn_pulse = 4'b0000; ifb.evt_ready = 1'b0;

        // Reset with all buttons pressed, then idle.
        drive(1'b0, 4'b1111, 1'b0, 4'b1111, 1'b0);
        drive(1'b0, 4'b1111, 1'b0, 4'b1111, 1'b0);
        started = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
            check("rst_a_valid", 32'(ifa.evt_valid), 32'd0);
            check("rst_a_count", 32'(ifa.count), 32'd0);
            check("rst_b_dropped", 32'(ifb.dropped), 32'd0);
        end

        // Priority, latency and hold-off on the LOCKOUT=16 instance.
        drive(1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("prio_valid", 32'(ifa.evt_valid), 32'd1);
        check("prio_dir",   32'(ifa.evt_dir),   32'd2);
        check("prio_count", 32'(ifa.count),     32'd1);
        for (int k = 2; k <= 16; k++) begin
            drive(1'b1, (k == 10) ? 4'b0001 : 4'b0000, 1'b0, 4'b0000, 1'b0);
            if (k == 11) check("holdoff_ignored", 32'(ifa.count), 32'd1);
        end
        drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("holdoff_accept", 32'(ifa.count), 32'd2);
        for (int k = 0; k < 3; k++) drive(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
        check("a_drained", 32'(ifa.evt_valid), 32'd0);

        // Fill and overflow on the LOCKOUT=0 instance.
        drive(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0);
        check("fill_count", 32'(ifb.count), 32'd4);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("ovf_dropped", 32'(ifb.dropped), 32'd1);
        check("ovf_count",   32'(ifb.count),   32'd4);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("ovf_pulse_end", 32'(ifb.dropped), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
            check("ovf_drain", 32'(ifb.evt_dir), 32'(k));
        end
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("ovf_empty", 32'(ifb.evt_valid), 32'd0);

        // Push and pop together while full.
        drive(1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b1);
        check("pp_full", 32'(ifb.count), 32'd4);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("pp_count",   32'(ifb.count),   32'd4);
        check("pp_dropped", 32'(ifb.dropped), 32'd0);
        exp_drain = '{2, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
            check("pp_drain", 32'(ifb.evt_dir), 32'(exp_drain[k]));
        end
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("pp_empty", 32'(ifb.evt_valid), 32'd0);

        // Wrap-around streaming with a consumer that is always ready.
        for (int k = 0; k < 20; k++) begin
            rb_b = 4'b0001 << (k % 4);
            drive(1'b1, 4'b0000, 1'b0, rb_b, 1'b1);
            check("wrap_count_le1", 32'(ifb.count <= 3'd1), 32'd1);
        end
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("wrap_empty", 32'(ifb.evt_valid), 32'd0);

        // Mid-operation reset with three entries queued and hold-off partly elapsed.
        for (int e = 0; e < 3; e++) begin
            drive(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0);
            for (int k = 0; k < ((e < 2) ? 16 : 7); k++)
                drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        end
        check("mid_count3", 32'(ifa.count), 32'd3);
        drive(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0);
        check("mid_rst_valid", 32'(ifa.evt_valid), 32'd0);
        check("mid_rst_count", 32'(ifa.count), 32'd0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        check("mid_post_count", 32'(ifa.count), 32'd1);
        check("mid_post_dir",   32'(ifa.evt_dir), 32'd2);

        // Randomised traffic on both instances, with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            ra_b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            rb_b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            drive(($urandom_range(0, 149) != 0), ra_b, 1'($urandom_range(0, 1)),
                  rb_b, 1'($urandom_range(0, 3) == 0));
        end
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
